// File: rtl/ice_bar_pkg.sv
// Shared encodings, FSM state codes and default constants for the ice-bar
// dispense controller and its timer.
package ice_bar_pkg;

    localparam int unsigned STOCK_W = 4;
    localparam int unsigned CHG_W   = 3;
    localparam int unsigned TMR_W   = 16;

    localparam int unsigned DEF_MOTOR_TO  = 16;
    localparam int unsigned DEF_PAY_TO    = 8;
    localparam int unsigned DEF_STOCK_MAX = 15;

    // Coin encodings used by the upstream vending FSM.
    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        NIS_2   = 2'd1,
        NIS_5   = 2'd2
    } coin_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_PAYOUT   = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

endpackage

// File: rtl/ice_bar_timer.sv
// Shared watchdog counter: clear, count enable and terminal-count compare
// against a runtime-selected limit (motor or payout timeout).
module ice_bar_timer
    import ice_bar_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] limit,
    output logic             tc_c
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    // High during the last allowed cycle of the current timed phase.
    assign tc_c = (cnt == (limit - TMR_W'(1)));

endmodule

// File: rtl/ice_bar_dispense_ctrl.sv
// Ice-bar dispense controller: runs the release motor, pays change one coin
// at a time through the hopper handshake, and tracks remaining stock.
module ice_bar_dispense_ctrl
    import ice_bar_pkg::*;
#(
    parameter int unsigned MOTOR_TO  = DEF_MOTOR_TO,
    parameter int unsigned PAY_TO    = DEF_PAY_TO,
    parameter int unsigned STOCK_MAX = DEF_STOCK_MAX
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               rls_in,
    input  logic [CHG_W-1:0]   change_in,
    input  logic               bar_sensed,
    input  logic               pay_ack,
    input  logic               refill,
    input  logic               clr_fault,
    output logic               coin_en,
    output logic               motor,
    output logic               pay_req,
    output logic [STOCK_W-1:0] stock,
    output logic               busy,
    output logic               fault
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [STOCK_W-1:0] stock_nxt;
    logic [CHG_W-1:0]   pay_cnt;
    logic [CHG_W-1:0]   pay_cnt_nxt;
    logic               motor_nxt;
    logic               pay_req_nxt;
    logic               evt_c;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc_c;
    logic [TMR_W-1:0]   tmr_limit;

    assign evt_c     = rls_in || (change_in != '0);
    assign tmr_limit = (state == ST_DISPENSE) ? TMR_W'(MOTOR_TO) : TMR_W'(PAY_TO);

    ice_bar_timer u_timer (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc_c  (tmr_tc_c)
    );

    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers; status flags decode the next state.
    always_ff @(posedge clk) begin
        if (nrst) begin
            stock   <= '0;
            pay_cnt <= '0;
            motor   <= 1'b0;
            pay_req <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            coin_en <= 1'b0;
        end else begin
            stock   <= stock_nxt;
            pay_cnt <= pay_cnt_nxt;
            motor   <= motor_nxt;
            pay_req <= pay_req_nxt;
            busy    <= (state_nxt != ST_IDLE);
            fault   <= (state_nxt == ST_FAULT);
            coin_en <= (state_nxt == ST_IDLE) && (stock_nxt != '0);
        end
    end

    always_comb begin
        state_nxt   = state;
        stock_nxt   = stock;
        pay_cnt_nxt = pay_cnt;
        motor_nxt   = 1'b0;
        pay_req_nxt = 1'b0;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (evt_c) begin
                    pay_cnt_nxt = change_in;
                    if (rls_in && (stock != '0)) begin
                        state_nxt = ST_DISPENSE;
                        motor_nxt = 1'b1;
                    end else if (change_in != '0) begin
                        state_nxt   = ST_PAYOUT;
                        pay_req_nxt = 1'b1;
                    end
                end else if (refill) begin
                    stock_nxt = STOCK_W'(STOCK_MAX);
                end
            end

            // A bar seen on the terminal cycle still counts as a normal drop.
            ST_DISPENSE: begin
                if (bar_sensed) begin
                    if (stock != '0) begin
                        stock_nxt = stock - STOCK_W'(1);
                    end
                    if (pay_cnt != '0) begin
                        state_nxt   = ST_PAYOUT;
                        pay_req_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (tmr_tc_c) begin
                    state_nxt = ST_FAULT;
                end else begin
                    motor_nxt = 1'b1;
                    tmr_clr   = 1'b0;
                    tmr_en    = 1'b1;
                end
            end

            // pay_req low for one cycle after each ack; acks in that gap are ignored.
            ST_PAYOUT: begin
                if (pay_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else if (pay_req) begin
                    if (pay_ack) begin
                        pay_cnt_nxt = pay_cnt - CHG_W'(1);
                        if (pay_cnt == CHG_W'(1)) begin
                            state_nxt = ST_IDLE;
                        end
                    end else if (tmr_tc_c) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        pay_req_nxt = 1'b1;
                        tmr_clr     = 1'b0;
                        tmr_en      = 1'b1;
                    end
                end else begin
                    pay_req_nxt = 1'b1;
                end
            end

            ST_FAULT: begin
                if (clr_fault) begin
                    state_nxt   = ST_IDLE;
                    pay_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ice_bar_dispense_ctrl.sv
// Self-checking bench for ice_bar_dispense_ctrl: directed scenarios plus
// randomized release/change transactions scored against a transaction-level model.
module tb_ice_bar_dispense_ctrl;

    localparam int MOTOR_TO  = 16;
    localparam int PAY_TO    = 8;
    localparam int STOCK_MAX = 15;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rls_in;
    logic [2:0] change_in;
    logic       bar_sensed;
    logic       pay_ack;
    logic       refill;
    logic       clr_fault;
    logic       coin_en;
    logic       motor;
    logic       pay_req;
    logic [3:0] stock;
    logic       busy;
    logic       fault;

    int n_assert = 0;
    int n_fail   = 0;
    int m_stock  = 0;
    int ack_d [8];

    ice_bar_dispense_ctrl #(
        .MOTOR_TO  (MOTOR_TO),
        .PAY_TO    (PAY_TO),
        .STOCK_MAX (STOCK_MAX)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .rls_in     (rls_in),
        .change_in  (change_in),
        .bar_sensed (bar_sensed),
        .pay_ack    (pay_ack),
        .refill     (refill),
        .clr_fault  (clr_fault),
        .coin_en    (coin_en),
        .motor      (motor),
        .pay_req    (pay_req),
        .stock      (stock),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transaction launched from IDLE. bar_at = motor cycle in which the bar
    // drops (beyond MOTOR_TO means never); ack_d[i] = pay_req cycle in which
    // coin i is acknowledged (beyond PAY_TO means never).
    task automatic txn(input bit rls, input int chg, input bit rf, input int bar_at, input bit noise);
        int e_stock, e_motor, e_coins, e_req, e_busy;
        bit e_fault;
        int mcyc, pcyc, coins, reqc, busyc;
        bit done, cen_bad;

        e_stock = m_stock;
        e_motor = 0;
        e_coins = 0;
        e_req   = 0;
        e_busy  = 0;
        e_fault = 1'b0;
        if (!rls && chg == 0) begin
            if (rf) e_stock = STOCK_MAX;
        end else begin
            if (rls && m_stock != 0) begin
                if (bar_at <= MOTOR_TO) begin
                    e_motor = bar_at;
                    e_stock = m_stock - 1;
                end else begin
                    e_motor = MOTOR_TO;
                    e_fault = 1'b1;
                end
                e_busy = e_motor;
            end
            if (!e_fault) begin
                for (int i = 0; i < chg; i++) begin
                    if (ack_d[i] <= PAY_TO) begin
                        e_coins++;
                        e_req  += ack_d[i];
                        e_busy += ack_d[i] + ((i < chg - 1) ? 1 : 0);
                    end else begin
                        e_req  += PAY_TO;
                        e_busy += PAY_TO;
                        e_fault = 1'b1;
                        break;
                    end
                end
            end
        end

        chk("pre_stock", int'(stock), m_stock);
        chk("pre_coin_en", int'(coin_en), int'(m_stock != 0));

        rls_in    = rls;
        change_in = 3'(chg);
        refill    = rf;
        mcyc = 0; pcyc = 0; coins = 0; reqc = 0; busyc = 0;
        done = 1'b0; cen_bad = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            rls_in     = 1'b0;
            change_in  = 3'd0;
            refill     = 1'b0;
            bar_sensed = 1'b0;
            pay_ack    = 1'b0;
            if (fault || !busy) begin
                done = 1'b1;
                break;
            end
            busyc++;
            if (coin_en) cen_bad = 1'b1;
            if (motor) begin
                mcyc++;
                if (mcyc == bar_at) bar_sensed = 1'b1;
            end
            if (pay_req) begin
                reqc++;
                pcyc++;
                if (coins < 8 && pcyc == ack_d[coins]) begin
                    pay_ack = 1'b1;
                    coins++;
                    pcyc = 0;
                end
            end else if (noise) begin
                pay_ack = 1'b1;
            end
        end

        chk("txn_done", int'(done), 1);
        chk("motor_cycles", mcyc, e_motor);
        chk("coins_paid", coins, e_coins);
        chk("pay_req_cycles", reqc, e_req);
        chk("busy_cycles", busyc, e_busy);
        chk("fault", int'(fault), int'(e_fault));
        chk("stock", int'(stock), e_stock);
        chk("coin_en_while_busy", int'(cen_bad), 0);

        if (e_fault || fault) begin
            clr_fault = 1'b1;
            @(negedge clk);
            clr_fault = 1'b0;
            chk("clr_fault_fault", int'(fault), 0);
            chk("clr_fault_busy", int'(busy), 0);
            chk("clr_fault_stock", int'(stock), e_stock);
        end
        chk("idle_coin_en", int'(coin_en), int'(e_stock != 0));
        m_stock = e_stock;
    endtask

    initial begin
        int seen;

        nrst       = 1'b1;
        rls_in     = 1'b0;
        change_in  = 3'd0;
        bar_sensed = 1'b0;
        pay_ack    = 1'b0;
        refill     = 1'b0;
        clr_fault  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_motor", int'(motor), 0);
        chk("rst_pay_req", int'(pay_req), 0);
        chk("rst_stock", int'(stock), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_coin_en", int'(coin_en), 0);
        nrst    = 1'b0;
        m_stock = 0;
        @(negedge clk);

        // Empty machine: change-only refund of four coins, no motor.
        ack_d = '{1, 2, 3, 1, 1, 1, 1, 1};
        txn(1'b1, 4, 1'b0, 1, 1'b0);

        // Refill from IDLE with no event.
        txn(1'b0, 0, 1'b1, 1, 1'b0);

        // Bar drops in third motor cycle, then two coins.
        ack_d = '{1, 2, 1, 1, 1, 1, 1, 1};
        txn(1'b1, 2, 1'b0, 3, 1'b0);

        // Jammed chute: motor watchdog, no coins paid.
        txn(1'b1, 3, 1'b0, 99, 1'b0);

        // Hopper stalls on the second coin; gap acks must be ignored.
        ack_d = '{2, 99, 1, 1, 1, 1, 1, 1};
        txn(1'b0, 3, 1'b0, 1, 1'b1);

        // Drain stock to 3, then refill colliding with a release.
        for (int k = 0; k < 11; k++) txn(1'b1, 0, 1'b0, 1, 1'b0);
        txn(1'b1, 0, 1'b1, 2, 1'b0);

        // Bar on the watchdog's last cycle is a normal drop.
        txn(1'b1, 0, 1'b0, MOTOR_TO, 1'b0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 8; i++) begin
                ack_d[i] = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(1, PAY_TO));
            end
            txn($urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)),
                $urandom_range(0, 4) == 0,
                int'($urandom_range(1, MOTOR_TO + 2)),
                $urandom_range(0, 1) == 1);
        end

        // Reset aborts a payout with three coins still owed.
        nrst = 1'b1;
        @(negedge clk);
        nrst    = 1'b0;
        m_stock = 0;
        rls_in    = 1'b1;
        change_in = 3'd3;
        @(negedge clk);
        rls_in    = 1'b0;
        change_in = 3'd0;
        for (int i = 0; i < 5 && !pay_req; i++) @(negedge clk);
        chk("pay_req_before_reset", int'(pay_req), 1);
        nrst = 1'b1;
        @(negedge clk);
        chk("abort_pay_req", int'(pay_req), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_stock", int'(stock), 0);
        chk("abort_fault", int'(fault), 0);
        nrst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (pay_req || busy) seen = 1;
        end
        chk("quiet_after_reset", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ice_bar_dispense_ctrl.md
ICE_BAR_DISPENSE_CTRL -- requirements
Module: ice_bar_dispense_ctrl

Interface
REQ-001 Parameter MOTOR_TO, default 16, max cycles the motor runs without bar_sensed before fault.
REQ-002 Parameter PAY_TO, default 8, max cycles pay_req stays high without pay_ack before fault.
REQ-003 Parameter STOCK_MAX, default 15, stock value loaded by refill (4-bit).
REQ-004 clk  in  1  clock; all logic on posedge clk.
REQ-005 nrst  in  1  reset, synchronous, active-high.
REQ-006 rls_in  in  1  one-cycle release request from the ice-bar vending FSM.
REQ-007 change_in  in  3  change owed in 1-NIS units, valid with rls_in or alone (change-only refund).
REQ-008 bar_sensed  in  1  drop sensor, high when a bar has left the chute.
REQ-009 pay_ack  in  1  coin hopper acknowledge for one 1-NIS coin.
REQ-010 refill  in  1  one-cycle stock reload request.
REQ-011 clr_fault  in  1  operator fault clear.
REQ-012 coin_en  out  1  coin acceptance enable to vending FSM.
REQ-013 motor  out  1  dispense motor drive.
REQ-014 pay_req  out  1  request hopper to eject one 1-NIS coin.
REQ-015 stock  out  4  bars remaining.
REQ-016 busy  out  1  controller not in IDLE.
REQ-017 fault  out  1  controller in FAULT.

Function
REQ-018 FSM states SHALL be IDLE, DISPENSE, PAYOUT, FAULT; all outputs registered.
REQ-019 IDLE: event = rls_in=1 or change_in!=0; on event latch change_in into pay_cnt (3-bit).
REQ-020 IDLE, rls_in=1, stock!=0 -> DISPENSE; motor=1 from the next cycle (1-cycle latency).
REQ-021 IDLE, rls_in=1, stock=0 -> no dispense; go PAYOUT if change_in!=0 else stay IDLE.
REQ-022 IDLE, rls_in=0, change_in!=0 -> PAYOUT.
REQ-023 DISPENSE: bar_sensed=1 -> motor=0, stock-=1 same edge, -> PAYOUT if pay_cnt!=0 else IDLE.
REQ-024 DISPENSE: timer reaches MOTOR_TO-1 with bar_sensed=0 -> FAULT, motor=0; bar_sensed on that same cycle wins (normal exit).
REQ-025 PAYOUT: pay_req=1 until pay_ack sampled high; on ack pay_cnt-=1, pay_req=0 next cycle for exactly one cycle, then reasserted if pay_cnt!=0.
REQ-026 PAYOUT: pay_cnt reaching 0 on ack -> IDLE.
REQ-027 PAYOUT: PAY_TO cycles of pay_req=1 without pay_ack -> FAULT; timer restarts per coin.
REQ-028 pay_ack while pay_req=0 SHALL be ignored.
REQ-029 FAULT: motor=0, pay_req=0, fault=1; exit only on clr_fault=1 -> IDLE with pay_cnt cleared, stock unchanged.
REQ-030 refill=1 in IDLE with no event -> stock=STOCK_MAX; refill in any other case ignored (event wins).
REQ-031 stock SHALL never wrap below 0; dispense never starts at stock=0.
REQ-032 coin_en = (state==IDLE) && stock!=0 && no event this cycle; busy = state!=IDLE; fault = state==FAULT.
REQ-033 rls_in/change_in outside IDLE SHALL be ignored (coin_en low guarantees none).

Reset
REQ-034 nrst=1 at a clock edge: state=IDLE, stock=0, pay_cnt=0, timer=0, motor=0, pay_req=0, busy=0, fault=0, coin_en=0.
REQ-035 nrst mid-DISPENSE or mid-PAYOUT SHALL abort immediately; pending change is discarded.
REQ-036 nrst SHALL take priority over every other input.

Structure
REQ-037 Package ice_bar_pkg SHALL hold the coin encodings (NOTHING, NIS_2, NIS_5), FSM state encoding and default timeout/stock constants.
REQ-038 One sub-module ice_bar_timer (clear, enable, terminal-count compare) SHALL serve both MOTOR_TO and PAY_TO.

Verification
REQ-039 Reset, refill, rls_in=1 change_in=2, bar_sensed at 3rd motor cycle -> motor 3 cycles, stock 15->14, two pay_req/pay_ack handshakes, IDLE, coin_en=1.
REQ-040 stock=0 after reset: rls_in=1 change_in=4 -> motor never high, four coins paid, stock stays 0, coin_en stays 0.
REQ-041 DISPENSE, bar_sensed held low -> fault=1 after exactly 16 motor cycles; clr_fault -> IDLE, stock unchanged, no coins paid.
REQ-042 PAYOUT, pay_ack withheld -> FAULT after 8 cycles of pay_req; pay_ack during pay_req=0 gap -> ignored, pay_cnt unchanged.
REQ-043 refill and rls_in same cycle in IDLE at stock=3 -> dispense proceeds, stock 3->2, not 15.
REQ-044 nrst asserted mid-PAYOUT with pay_cnt=3 -> next cycle pay_req=0, busy=0, stock=0, no further coins.
